// File: rtl/dmem_stall_ctrl.sv
// Data-memory front-end for the single-cycle MIPS datapath: runs a req/ack
// handshake to a variable-latency word memory and stalls the datapath until the access retires.
module dmem_stall_ctrl #(
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       read_data,
    output logic              stall,
    output logic              misalign,
    output logic              timeout_err,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    input  logic              m_ack,
    output logic [1:0]        dbg_state
);

    // Handshake: m_req rises on the edge that enters BUSY and stays high, with
    // m_we/m_addr/m_wdata frozen, until the edge on which m_ack=1 is sampled in
    // BUSY (or the wait budget runs out); m_ack is don't-care whenever m_req=0.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    if ((2 ** CNT_W) <= TIMEOUT_CYCLES || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("dmem_stall_ctrl: CNT_W too small for TIMEOUT_CYCLES");
    end

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_counter;
    logic             w_access;
    logic             w_aligned;
    logic             w_launch;
    logic             w_wait_over;
    logic             w_unused_addr;

    assign w_access    = mem_read | mem_write;
    assign w_aligned   = (addr[1:0] == 2'b00);
    assign w_launch    = (r_state == S_IDLE) && w_access && w_aligned;
    assign w_wait_over = (r_counter == CNT_W'(TIMEOUT_CYCLES - 1));

    // Upper address bits are deliberately dropped: the word address wraps.
    assign w_unused_addr = ^addr[31:ADDR_W+2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // DONE always returns to IDLE, so the instruction still holding
    // mem_read/mem_write during its commit cycle cannot relaunch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (m_ack || w_wait_over) begin
                    w_next = S_DONE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Gated by rst so the datapath sees no stall while reset is held, even
    // if the abandoned instruction keeps its request asserted.
    assign stall     = rst && (w_launch || (r_state == S_BUSY));
    assign misalign  = rst && (r_state == S_IDLE) && w_access && !w_aligned;
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_req       <= 1'b0;
            m_we        <= 1'b0;
            m_addr      <= '0;
            m_wdata     <= '0;
            read_data   <= '0;
            timeout_err <= 1'b0;
            r_counter   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        m_req     <= 1'b1;
                        m_we      <= mem_write;
                        m_addr    <= addr[ADDR_W+1:2];
                        m_wdata   <= wdata;
                        r_counter <= '0;
                    end
                end
                S_BUSY: begin
                    if (m_ack) begin
                        m_req <= 1'b0;
                        if (!m_we) begin
                            read_data <= m_rdata;
                        end
                    end else if (w_wait_over) begin
                        m_req       <= 1'b0;
                        timeout_err <= 1'b1;
                        // A timed-out store leaves read_data alone.
                        if (!m_we) begin
                            read_data <= '0;
                        end
                    end else begin
                        r_counter <= r_counter + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_stall_ctrl.md
Name: dmem_stall_ctrl

Overview:
- Data-memory front-end directly downstream of the single-cycle MIPS datapath's ALU.
- Consumes the datapath's memory address (ALU result), store data (register read port 2), and mem_read/mem_write controls.
- Runs a req/ack handshake to a variable-latency word memory and returns load data.
- Drives a stall line that freezes the PC and register-file write until the access completes. Also flags misaligned accesses and memory timeouts.

Parameters:
ADDR_W, 10, word-address width on memory side; m_addr = addr[ADDR_W+1:2]
TIMEOUT_CYCLES, 64, max BUSY cycles waiting for m_ack before abort (>=1)
CNT_W, 7, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
mem_read  input  1  load request from control, level, held while stalled
mem_write  input  1  store request from control, level, held while stalled
addr  input  32  byte address (ALU result)
wdata  input  32  store data
read_data  output  32  load result, registered
stall  output  1  hold PC/pipeline; datapath must not commit while high
misalign  output  1  combinational: access requested with addr[1:0]!=0
timeout_err  output  1  sticky: an access timed out
m_req  output  1  memory request, registered
m_we  output  1  1=write, 0=read; valid with m_req
m_addr  output  ADDR_W  word address; valid with m_req
m_wdata  output  32  write data; valid with m_req
m_rdata  input  32  read data, valid when m_ack=1
m_ack  input  1  completes current request; ignored when m_req=0

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, m_req=0, m_we=0, m_addr=0, m_wdata=0, read_data=0, timeout_err=0, counter=0. stall=0, misalign=0. Reset mid-access drops m_req immediately; the access is abandoned.
- access = mem_read|mem_write. If both are high, the access is a write.
- IDLE:
  - access & addr[1:0]==0: stall=1 combinationally this cycle. Capture m_addr=addr[ADDR_W+1:2], m_wdata=wdata, m_we=mem_write. Set m_req=1, counter=0, go BUSY.
  - access & addr[1:0]!=0: misalign=1, no request, stall=0, read_data unchanged.
  - no access: outputs idle.
- BUSY: stall=1; m_req, m_we, m_addr, m_wdata held stable.
  - m_ack=1: m_req=0; if read, read_data<=m_rdata; go DONE.
  - else if counter==TIMEOUT_CYCLES-1: m_req=0, timeout_err<=1, read_data<=0; go DONE.
  - else counter<=counter+1.
- DONE: stall=0, no new request launched even though mem_read/mem_write is still asserted by the same instruction. Datapath commits at the end of this cycle. Next state is IDLE unconditionally.
- Latency: ack in first BUSY cycle gives stall high for 2 cycles, read_data valid in the DONE cycle (3rd cycle). Each extra wait cycle adds one stall cycle.
- Max stall: TIMEOUT_CYCLES+1 cycles.
- timeout_err clears only on reset.
- Stores never modify read_data.
- m_ack outside BUSY has no effect.
- Address bits above ADDR_W+1 are ignored (wrap).

Test Plan:
- Read, ack in 1st BUSY cycle: addr=0x10, m_rdata=0xCAFEF00D -> m_addr=4, m_we=0; stall high 2 cycles; read_data=0xCAFEF00D in DONE; m_req high exactly 1 cycle.
- Write, ack after 3 wait cycles: addr=0x24, wdata=0x12345678 -> m_we=1, m_addr=9, m_wdata=0x12345678 stable 4 cycles; stall high 5 cycles; read_data unchanged.
- Misaligned: mem_read=1, addr=0x13 -> misalign=1, stall=0, m_req never asserts.
- Timeout: TIMEOUT_CYCLES=4, read at addr=0x8, no ack -> m_req high 4 cycles then low; timeout_err=1 sticky; read_data=0; following aligned read with ack still completes.
- Back-to-back: two consecutive load instructions -> DONE cycle launches nothing; second request starts the cycle after DONE; no duplicate m_req.
- Reset mid-BUSY: rst low during wait -> m_req, stall, read_data, timeout_err all 0 immediately; late m_ack after reset release ignored.
- Both mem_read and mem_write=1 -> access is a write (m_we=1).
